// File: rtl/polmul_result_writeback.sv
// Drains the polynomial multiplier accumulator into the result BRAM, unpacked or bit-packed.
// Optional build macro WB_CHECKSUM_EN adds a running XOR checksum of written words.
module polmul_result_writeback #(
  parameter int unsigned NUM_WORDS  = 64,
  parameter int unsigned COEFF_BITS = 10,
  parameter int unsigned ADDR_W     = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pack_mode,
  input  logic              pol_mul_done,
  input  logic [63:0]       coeff4x_in,
  output logic              read,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [63:0]       wr_data,
  output logic              busy,
  output logic              done
`ifdef WB_CHECKSUM_EN
  ,
  output logic [63:0]       checksum
`endif
);

  localparam int unsigned CntW  = $clog2(NUM_WORDS);
  localparam int unsigned PackW = 4 * COEFF_BITS;
  localparam int unsigned BufW  = 64 + PackW - 1;
  localparam int unsigned FillW = $clog2(BufW + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(NUM_WORDS - 1);
  localparam logic [15:0] LaneMask = 16'((1 << COEFF_BITS) - 1);
  localparam logic [63:0] WordMask = {4{LaneMask}};

  typedef enum logic [2:0] {StIdle, StWaitMul, StDrain, StFlush, StDone} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    word_cnt_q, word_cnt_d;
  logic               pack_q, pack_d;
  logic [BufW-1:0]    buf_q, buf_d;
  logic [FillW-1:0]   fill_q, fill_d;
  logic [ADDR_W-1:0]  next_addr_q, next_addr_d;
  logic               wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_d;
  logic [63:0]        wr_data_d;

  logic               start_acc;
  logic               emit;
  logic [63:0]        emit_data;
  logic [PackW-1:0]   packed_w;
  logic [BufW-1:0]    appended;
  logic [FillW-1:0]   fill_sum;

  // Gather the valid low bits of each lane into one dense field, lane 0 lowest.
  always_comb begin
    packed_w = '0;
    for (int i = 0; i < 4; i++) begin
      packed_w[i*COEFF_BITS +: COEFF_BITS] = coeff4x_in[i*16 +: COEFF_BITS];
    end
  end

  assign appended = buf_q | (BufW'(packed_w) << fill_q);
  assign fill_sum = fill_q + FillW'(PackW);

  assign read = (state_q == StDrain);
  assign busy = (state_q == StWaitMul) || (state_q == StDrain) || (state_q == StFlush);
  assign done = (state_q == StDone);

  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    pack_d      = pack_q;
    buf_d       = buf_q;
    fill_d      = fill_q;
    next_addr_d = next_addr_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr;
    wr_data_d   = wr_data;
    start_acc   = 1'b0;
    emit        = 1'b0;
    emit_data   = '0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          start_acc   = 1'b1;
          state_d     = StWaitMul;
          pack_d      = pack_mode;
          word_cnt_d  = '0;
          buf_d       = '0;
          fill_d      = '0;
          next_addr_d = '0;
          wr_addr_d   = '0;
        end
      end
      StWaitMul: begin
        if (pol_mul_done) state_d = StDrain;
      end
      StDrain: begin
        word_cnt_d = word_cnt_q + 1'b1;
        if (word_cnt_q == LastCnt) state_d = StFlush;
        if (!pack_q) begin
          emit      = 1'b1;
          emit_data = coeff4x_in & WordMask;
        end else if (fill_sum >= FillW'(64)) begin
          // Append and emit in one step; only the sub-64-bit residue stays buffered.
          emit      = 1'b1;
          emit_data = appended[63:0];
          buf_d     = appended >> 64;
          fill_d    = fill_sum - FillW'(64);
        end else begin
          buf_d  = appended;
          fill_d = fill_sum;
        end
      end
      StFlush: begin
        state_d = StDone;
        if (pack_q && (fill_q != '0)) begin
          emit      = 1'b1;
          emit_data = buf_q[63:0];
          buf_d     = '0;
          fill_d    = '0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (emit) begin
      wr_en_d     = 1'b1;
      wr_data_d   = emit_data;
      wr_addr_d   = next_addr_q;
      next_addr_d = next_addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      word_cnt_q  <= '0;
      pack_q      <= 1'b0;
      buf_q       <= '0;
      fill_q      <= '0;
      next_addr_q <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      pack_q      <= pack_d;
      buf_q       <= buf_d;
      fill_q      <= fill_d;
      next_addr_q <= next_addr_d;
      wr_en       <= wr_en_d;
      wr_addr     <= wr_addr_d;
      wr_data     <= wr_data_d;
    end
  end

`ifdef WB_CHECKSUM_EN
  logic [63:0] cks_q;

  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      cks_q <= '0;
    end else if (emit) begin
      cks_q <= cks_q ^ emit_data;
    end
  end

  assign checksum = cks_q;
`endif

endmodule
